// File: rtl/compressor_sched_pkg.sv
// Shared types and helpers for the compressor scheduler: FSM encoding, channel
// count and the channel-mask popcount.
package compressor_sched_pkg;

  localparam int unsigned NUM_CHANS  = 64;
  localparam int unsigned CHAN_IDX_W = 7;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StReq  = 2'b01,
    StBusy = 2'b11
  } sched_state_e;

  function automatic logic [CHAN_IDX_W-1:0] popcount(input logic [NUM_CHANS-1:0] v);
    logic [CHAN_IDX_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_CHANS; i++) begin
      n = n + CHAN_IDX_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Frame-period down-counter: emits a 1-cycle tick every max(period,2) cycles
// while enabled. A new period is picked up at the next reload.
module frame_tick_gen #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic [DIV_WIDTH-1:0] period_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] count_q, count_d;
  logic [DIV_WIDTH-1:0] reload;

  always_comb begin
    // Periods of 0 and 1 behave as 2.
    reload  = (period_i < DIV_WIDTH'(2)) ? DIV_WIDTH'(1) : period_i - DIV_WIDTH'(1);
    tick_o  = enable_i && (count_q == '0);
    count_d = (!enable_i || (count_q == '0)) ? reload : count_q - DIV_WIDTH'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/compressor_scheduler.sv
// Frame sequencer for the ADC vector compressor: issues start requests on period
// ticks, tracks frames to completion or CRC failure, and commits mask updates between frames.
module compressor_scheduler
  import compressor_sched_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 16,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  enable,
  input  logic [DIV_WIDTH-1:0]  period,
  input  logic [NUM_CHANS-1:0]  cfg_mask,
  input  logic                  cfg_mask_wr,
  input  logic                  fifo_full,
  input  logic                  pkt_done,
  input  logic                  crc_ok,
  input  logic                  frame_rdy,
  output logic                  start,
  output logic [NUM_CHANS-1:0]  vector_bits,
  output logic [CHAN_IDX_W-1:0] active_chans,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  frames_done,
  output logic [CNT_WIDTH-1:0]  frames_dropped,
  output logic [CNT_WIDTH-1:0]  crc_errors
);

  sched_state_e          state_q, state_d;
  logic                  start_q, start_d;
  logic                  pend_tick_q, pend_tick_d;
  logic                  mask_pend_q, mask_pend_d;
  logic [NUM_CHANS-1:0]  shadow_q, shadow_d;
  logic [NUM_CHANS-1:0]  vector_bits_q, vector_bits_d;
  logic [CHAN_IDX_W-1:0] active_chans_q, active_chans_d;
  logic [CNT_WIDTH-1:0]  frames_done_q, frames_done_d;
  logic [CNT_WIDTH-1:0]  frames_dropped_q, frames_dropped_d;
  logic [CNT_WIDTH-1:0]  crc_errors_q, crc_errors_d;
  logic                  tick;
  logic                  commit;

  frame_tick_gen #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_tick_gen (
    .clk_i   (clk),
    .rst_ni  (rstb),
    .enable_i(enable),
    .period_i(period),
    .tick_o  (tick)
  );

  always_comb begin
    state_d          = state_q;
    start_d          = start_q;
    pend_tick_d      = pend_tick_q;
    mask_pend_d      = mask_pend_q;
    shadow_d         = shadow_q;
    vector_bits_d    = vector_bits_q;
    active_chans_d   = active_chans_q;
    frames_done_d    = frames_done_q;
    frames_dropped_d = frames_dropped_q;
    crc_errors_d     = crc_errors_q;

    commit = (state_q == StIdle) && mask_pend_q;
    if (commit) begin
      vector_bits_d  = shadow_q;
      active_chans_d = popcount(shadow_q);
      mask_pend_d    = 1'b0;
    end
    // A write in the commit cycle re-arms the pending flag so it is not lost.
    if (cfg_mask_wr) begin
      shadow_d    = cfg_mask;
      mask_pend_d = 1'b1;
    end

    if (tick && (state_q != StIdle)) begin
      if (!pend_tick_q) begin
        pend_tick_d = 1'b1;
      end else if (frames_dropped_q != '1) begin
        frames_dropped_d = frames_dropped_q + CNT_WIDTH'(1);
      end
    end

    unique case (state_q)
      StIdle: begin
        if (enable && (tick || pend_tick_q)) begin
          if (commit) begin
            pend_tick_d = 1'b1;
          end else begin
            state_d     = StReq;
            start_d     = 1'b1;
            pend_tick_d = 1'b0;
          end
        end
      end
      StReq: begin
        if (!enable) begin
          state_d = StIdle;
          start_d = 1'b0;
        end else if (start_q && !fifo_full) begin
          state_d = StBusy;
          start_d = 1'b0;
        end
      end
      StBusy: begin
        if (frame_rdy) begin
          state_d = StIdle;
          if (frames_done_q != '1) frames_done_d = frames_done_q + CNT_WIDTH'(1);
        end else if (pkt_done && !crc_ok) begin
          state_d = StIdle;
          if (crc_errors_q != '1) crc_errors_d = crc_errors_q + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = StIdle;
        start_d = 1'b0;
      end
    endcase

    if (!enable) pend_tick_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q          <= StIdle;
      start_q          <= 1'b0;
      pend_tick_q      <= 1'b0;
      mask_pend_q      <= 1'b0;
      shadow_q         <= '0;
      vector_bits_q    <= '0;
      active_chans_q   <= '0;
      frames_done_q    <= '0;
      frames_dropped_q <= '0;
      crc_errors_q     <= '0;
    end else begin
      state_q          <= state_d;
      start_q          <= start_d;
      pend_tick_q      <= pend_tick_d;
      mask_pend_q      <= mask_pend_d;
      shadow_q         <= shadow_d;
      vector_bits_q    <= vector_bits_d;
      active_chans_q   <= active_chans_d;
      frames_done_q    <= frames_done_d;
      frames_dropped_q <= frames_dropped_d;
      crc_errors_q     <= crc_errors_d;
    end
  end

  assign start          = start_q;
  assign vector_bits    = vector_bits_q;
  assign active_chans   = active_chans_q;
  assign busy           = (state_q != StIdle);
  assign frames_done    = frames_done_q;
  assign frames_dropped = frames_dropped_q;
  assign crc_errors     = crc_errors_q;

endmodule

// File: tb/tb_compressor_scheduler.sv
// Directed bench for compressor_scheduler, with a small compressor model that
// answers each accepted start with frame_rdy after a programmable delay.
module tb_compressor_scheduler;

  logic        clk;
  logic        rstb;
  logic        enable;
  logic [15:0] period;
  logic [63:0] cfg_mask;
  logic        cfg_mask_wr;
  logic        fifo_full;
  logic        pkt_done;
  logic        crc_ok;
  logic        frame_rdy;
  logic        start;
  logic [63:0] vector_bits;
  logic [6:0]  active_chans;
  logic        busy;
  logic [15:0] frames_done;
  logic [15:0] frames_dropped;
  logic [15:0] crc_errors;

  // Second instance with 3-bit counters so saturation is reachable quickly.
  logic        start_s;
  logic [63:0] vector_bits_s;
  logic [6:0]  active_chans_s;
  logic        busy_s;
  logic [2:0]  frames_done_s;
  logic [2:0]  frames_dropped_s;
  logic [2:0]  crc_errors_s;

  int chk_cnt;
  int pass_cnt;
  int cyc, n_starts, last_rise, bad_gap, long_start, frm_cnt, frm_delay, n_frm, period_exp;
  bit model_on;
  logic start_prev;

  compressor_scheduler dut (
    .clk           (clk),
    .rstb          (rstb),
    .enable        (enable),
    .period        (period),
    .cfg_mask      (cfg_mask),
    .cfg_mask_wr   (cfg_mask_wr),
    .fifo_full     (fifo_full),
    .pkt_done      (pkt_done),
    .crc_ok        (crc_ok),
    .frame_rdy     (frame_rdy),
    .start         (start),
    .vector_bits   (vector_bits),
    .active_chans  (active_chans),
    .busy          (busy),
    .frames_done   (frames_done),
    .frames_dropped(frames_dropped),
    .crc_errors    (crc_errors)
  );

  compressor_scheduler #(
    .CNT_WIDTH(3)
  ) dut_sat (
    .clk           (clk),
    .rstb          (rstb),
    .enable        (enable),
    .period        (period),
    .cfg_mask      (cfg_mask),
    .cfg_mask_wr   (cfg_mask_wr),
    .fifo_full     (fifo_full),
    .pkt_done      (pkt_done),
    .crc_ok        (crc_ok),
    .frame_rdy     (frame_rdy),
    .start         (start_s),
    .vector_bits   (vector_bits_s),
    .active_chans  (active_chans_s),
    .busy          (busy_s),
    .frames_done   (frames_done_s),
    .frames_dropped(frames_dropped_s),
    .crc_errors    (crc_errors_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: compressor model, start-pulse bookkeeping, outputs settled at edge+1.
  task automatic step();
    logic acc;
    acc = start && !fifo_full;
    @(posedge clk);
    #1;
    frame_rdy = 1'b0;
    if (frm_cnt != 0) begin
      frm_cnt--;
      if (frm_cnt == 0 && model_on) begin
        frame_rdy = 1'b1;
        n_frm++;
      end
    end
    if (acc && model_on) frm_cnt = frm_delay;
    cyc++;
    if (start && !start_prev) begin
      if (n_starts > 0 && (cyc - last_rise) != period_exp) bad_gap++;
      last_rise = cyc;
      n_starts++;
    end
    if (start && start_prev) long_start++;
    start_prev = start;
  endtask

  task automatic do_reset();
    rstb = 1'b0;
    enable = 1'b0; period = '0; cfg_mask = '0; cfg_mask_wr = 1'b0; fifo_full = 1'b0;
    pkt_done = 1'b0; crc_ok = 1'b0; frame_rdy = 1'b0;
    frm_cnt = 0; frm_delay = 0; model_on = 1'b0; n_frm = 0; cyc = 0; n_starts = 0;
    last_rise = 0; bad_gap = 0; long_start = 0; start_prev = 1'b0; period_exp = 0;
    @(posedge clk);
    #1;
    rstb = 1'b1;
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    enable = 1'b0; period = '0; cfg_mask = '0; cfg_mask_wr = 1'b0; fifo_full = 1'b0;
    pkt_done = 1'b0; crc_ok = 1'b0; frame_rdy = 1'b0;
    @(posedge clk);
    #1;
    chk_cnt++;
    if ({start, busy, vector_bits, active_chans, frames_done, frames_dropped, crc_errors} !== '0)
      $display("FAIL reset_outputs: got start=%b busy=%b vb=%h ac=%0d fd=%0d fdr=%0d ce=%0d want all 0",
               start, busy, vector_bits, active_chans, frames_done, frames_dropped, crc_errors);
    else pass_cnt++;
    do_reset();
    step();
    chk_cnt++;
    if ({start, busy, vector_bits, active_chans} !== '0)
      $display("FAIL reset_idle_disabled: got start=%b busy=%b vb=%h want 0", start, busy, vector_bits);
    else pass_cnt++;
  endtask

  task automatic test_basic_frame();
    do_reset();
    enable = 1'b1; period = 16'd100; model_on = 1'b1; frm_delay = 80; period_exp = 100;
    repeat (1000) step();
    chk_cnt++;
    if (n_starts != 10) $display("FAIL basic_start_count: got %0d want 10", n_starts);
    else pass_cnt++;
    chk_cnt++;
    if (bad_gap != 0) $display("FAIL basic_start_spacing: got %0d bad gaps want 0", bad_gap);
    else pass_cnt++;
    chk_cnt++;
    if (long_start != 0) $display("FAIL basic_start_width: got %0d extra cycles want 0", long_start);
    else pass_cnt++;
    chk_cnt++;
    if (frames_done !== 16'd10) $display("FAIL basic_frames_done: got %0d want 10", frames_done);
    else pass_cnt++;
    chk_cnt++;
    if (frames_dropped !== 16'd0) $display("FAIL basic_dropped: got %0d want 0", frames_dropped);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int low_cnt;
    do_reset();
    fifo_full = 1'b1; enable = 1'b1; period = 16'd100;
    low_cnt = 0;
    repeat (250) begin
      step();
      if (start !== 1'b1) low_cnt++;
    end
    chk_cnt++;
    if (low_cnt != 0) $display("FAIL bp_start_held: got %0d low cycles want 0", low_cnt);
    else pass_cnt++;
    chk_cnt++;
    if (frames_dropped !== 16'd1) $display("FAIL bp_dropped: got %0d want 1", frames_dropped);
    else pass_cnt++;
    fifo_full = 1'b0;
    step();
    chk_cnt++;
    if ({start, busy} !== 2'b01) $display("FAIL bp_accept_next: got start=%b busy=%b want 0 1", start, busy);
    else pass_cnt++;
    chk_cnt++;
    if (frames_dropped !== 16'd1) $display("FAIL bp_dropped_after: got %0d want 1", frames_dropped);
    else pass_cnt++;
  endtask

  task automatic test_crc_failure();
    do_reset();
    enable = 1'b1; period = 16'd100;
    step();
    step();
    chk_cnt++;
    if ({start, busy} !== 2'b01) $display("FAIL crc_enter_busy: got start=%b busy=%b want 0 1", start, busy);
    else pass_cnt++;
    pkt_done = 1'b1; crc_ok = 1'b1;
    step();
    pkt_done = 1'b0;
    chk_cnt++;
    if ({busy, crc_errors} !== {1'b1, 16'd0})
      $display("FAIL crc_good_pkt: got busy=%b ce=%0d want 1 0", busy, crc_errors);
    else pass_cnt++;
    pkt_done = 1'b1; crc_ok = 1'b0;
    step();
    pkt_done = 1'b0;
    chk_cnt++;
    if ({busy, crc_errors, frames_done} !== {1'b0, 16'd1, 16'd0})
      $display("FAIL crc_bad_pkt: got busy=%b ce=%0d fd=%0d want 0 1 0", busy, crc_errors, frames_done);
    else pass_cnt++;
    for (int i = 0; i < 200 && !(busy && !start); i++) step();
    chk_cnt++;
    if ({start, busy} !== 2'b01) $display("FAIL crc_second_frame: got start=%b busy=%b want 0 1", start, busy);
    else pass_cnt++;
    frame_rdy = 1'b1; pkt_done = 1'b1; crc_ok = 1'b0;
    step();
    pkt_done = 1'b0;
    chk_cnt++;
    if ({busy, frames_done, crc_errors} !== {1'b0, 16'd1, 16'd1})
      $display("FAIL crc_simultaneous: got busy=%b fd=%0d ce=%0d want 0 1 1", busy, frames_done, crc_errors);
    else pass_cnt++;
  endtask

  task automatic test_mask_deferral();
    int vb_moved;
    do_reset();
    enable = 1'b1; period = 16'd100; model_on = 1'b1; frm_delay = 20;
    step();
    step();
    cfg_mask = 64'h0000_0000_FFFF_00F0; cfg_mask_wr = 1'b1;
    step();
    cfg_mask_wr = 1'b0;
    vb_moved = (vector_bits !== 64'd0) ? 1 : 0;
    for (int i = 0; i < 100 && busy; i++) begin
      step();
      if (vector_bits !== 64'd0) vb_moved++;
    end
    chk_cnt++;
    if ({busy, frames_done} !== {1'b0, 16'd1})
      $display("FAIL mask_frame_end: got busy=%b fd=%0d want 0 1", busy, frames_done);
    else pass_cnt++;
    chk_cnt++;
    if (vb_moved != 0) $display("FAIL mask_deferred: got %0d early changes want 0", vb_moved);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (vector_bits !== 64'h0000_0000_FFFF_00F0)
      $display("FAIL mask_commit: got %h want 00000000ffff00f0", vector_bits);
    else pass_cnt++;
    chk_cnt++;
    if (active_chans !== 7'd20) $display("FAIL mask_popcount20: got %0d want 20", active_chans);
    else pass_cnt++;
    cfg_mask = '1; cfg_mask_wr = 1'b1;
    step();
    cfg_mask_wr = 1'b0;
    step();
    chk_cnt++;
    if ({vector_bits, active_chans} !== {64'hFFFF_FFFF_FFFF_FFFF, 7'd64})
      $display("FAIL mask_all_ones: got vb=%h ac=%0d want all ones 64", vector_bits, active_chans);
    else pass_cnt++;
  endtask

  task automatic test_period_clamp();
    logic [15:0] plist [2];
    plist[0] = 16'd0;
    plist[1] = 16'd1;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      fifo_full = 1'b1; enable = 1'b1; period = plist[k];
      // Ticks land at edges 1,3,...,21: first starts REQ, next pends, rest drop.
      repeat (21) step();
      chk_cnt++;
      if (frames_dropped !== 16'd9)
        $display("FAIL period_clamp_p%0d: got %0d dropped want 9", plist[k], frames_dropped);
      else pass_cnt++;
    end
  endtask

  task automatic test_saturation();
    do_reset();
    enable = 1'b1; period = 16'd2; model_on = 1'b1; frm_delay = 1;
    repeat (60) step();
    chk_cnt++;
    if (frames_done !== 16'(n_frm) || n_frm != 15)
      $display("FAIL sat_wide_count: got %0d want 15 (model %0d)", frames_done, n_frm);
    else pass_cnt++;
    chk_cnt++;
    if (frames_done_s !== 3'd7) $display("FAIL sat_narrow_count: got %0d want 7", frames_done_s);
    else pass_cnt++;
  endtask

  task automatic test_enable_drop();
    do_reset();
    fifo_full = 1'b1; enable = 1'b1; period = 16'd100;
    step();
    chk_cnt++;
    if ({start, busy} !== 2'b11) $display("FAIL en_drop_req: got start=%b busy=%b want 1 1", start, busy);
    else pass_cnt++;
    enable = 1'b0;
    step();
    chk_cnt++;
    if ({start, busy, frames_done, frames_dropped, crc_errors} !== '0)
      $display("FAIL en_drop_abort: got start=%b busy=%b fd=%0d fdr=%0d ce=%0d want 0",
               start, busy, frames_done, frames_dropped, crc_errors);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    do_reset();
    cfg_mask = 64'h0000_0000_0000_00A5; cfg_mask_wr = 1'b1;
    step();
    cfg_mask_wr = 1'b0;
    step();
    enable = 1'b1; period = 16'd2;
    for (int i = 0; i < 20 && !(busy && !start); i++) step();
    chk_cnt++;
    if ({start, busy, vector_bits, active_chans} !== {1'b0, 1'b1, 64'hA5, 7'd4})
      $display("FAIL arst_setup: got start=%b busy=%b vb=%h ac=%0d want 0 1 a5 4",
               start, busy, vector_bits, active_chans);
    else pass_cnt++;
    #3;
    rstb = 1'b0;
    #1;
    chk_cnt++;
    if ({start, busy, vector_bits, active_chans, frames_done, frames_dropped, crc_errors,
         start_s, busy_s, vector_bits_s, active_chans_s, frames_done_s, frames_dropped_s,
         crc_errors_s} !== '0)
      $display("FAIL arst_mid_busy: got start=%b busy=%b vb=%h ac=%0d fdr=%0d want all 0",
               start, busy, vector_bits, active_chans, frames_dropped);
    else pass_cnt++;
    @(posedge clk);
    #1;
    rstb = 1'b1;
  endtask

  initial begin
    chk_cnt = 0;
    pass_cnt = 0;
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_crc_failure();
    test_mask_deferral();
    test_period_clamp();
    test_saturation();
    test_enable_drop();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/compressor_scheduler.md
# compressor_scheduler

Sequencer for `adc_vector_compressor`: turns a programmable sample period into `start` requests, holds each request until the compressor accepts it, and tracks each frame to completion or CRC failure. Owns the live 64-bit channel-select mask (`vector_bits`), and changes it only between frames. Counts completed, dropped and CRC-failed frames for the host register file. Sits between the host config/status registers and the compressor, alongside the serial packet receiver that drives `pkt_done`/`crc_ok`.

## Interface
- `DIV_WIDTH`, 16: width of sample-period register.
- `CNT_WIDTH`, 16: width of each status counter.
- `clk` in 1: system clock.
- `rstb` in 1: asynchronous, active-low reset.
- `enable` in 1: level; 1 = generate frame ticks.
- `period` in DIV_WIDTH: tick period in clk cycles; values 0 and 1 are treated as 2.
- `cfg_mask` in 64: new channel mask.
- `cfg_mask_wr` in 1: 1-cycle pulse; captures `cfg_mask` into the shadow register.
- `fifo_full` in 1: compressor FIFO full.
- `pkt_done` in 1: packet-complete pulse from the receiver.
- `crc_ok` in 1: qualifies `pkt_done`.
- `frame_rdy` in 1: compressor end-of-frame pulse.
- `start` out 1: request to compressor; registered.
- `vector_bits` out 64: live channel mask; registered.
- `active_chans` out 7: popcount of `vector_bits` (0..64); registered.
- `busy` out 1: a frame is requested or in flight.
- `frames_done` out CNT_WIDTH: count of `frame_rdy` events seen in the BUSY state.
- `frames_dropped` out CNT_WIDTH: count of ticks lost to overrun.
- `crc_errors` out CNT_WIDTH: count of frames ended by `pkt_done && !crc_ok`.

## Operation
- **Reset values:** all outputs 0 (`vector_bits` = 0, `active_chans` = 0). Shadow mask = 0, mask-pending = 0, state = IDLE, tick counter = 0.
- **Tick generator:**
  - Down-counter loads `max(period,2)-1` whenever `enable` is 0 or the count reaches 0.
  - `tick` = (count == 0) && `enable`, so a tick fires every `max(period,2)` cycles.
  - A change to `period` takes effect at the next reload.
- **Mask handling:**
  - `cfg_mask_wr` writes the shadow register and sets mask-pending.
  - In IDLE with mask-pending set, `vector_bits` ← shadow, `active_chans` ← popcount(shadow), and mask-pending clears. The commit takes one cycle and blocks a start in that same cycle.
  - A write during REQ or BUSY is deferred until the next IDLE. Back-to-back writes: the last one wins.
- **FSM states: IDLE, REQ, BUSY.**
  - IDLE → REQ on tick (or a pending tick), provided no mask commit is happening that cycle. `start` is set to 1 on the transition.
  - REQ: `start` is held at 1.
    - Acceptance = `start && !fifo_full` at a clock edge. On acceptance: `start` ← 0, go to BUSY.
    - `enable` falling during REQ: `start` ← 0, return to IDLE, no count.
  - BUSY:
    - `frame_rdy` → `frames_done`++, go to IDLE.
    - `pkt_done && !crc_ok` → `crc_errors`++, go to IDLE.
    - `pkt_done && crc_ok` → stay in BUSY.
    - `enable` falling → the in-flight frame still completes.
- **Pending tick:**
  - Depth is one.
  - A tick arriving while in REQ or BUSY sets pending-tick if it is clear; otherwise `frames_dropped`++.
  - A tick in REQ with pending already set drops the new tick.
  - Pending-tick is consumed on the IDLE → REQ transition and cleared when `enable` = 0.
- `busy` = (state != IDLE).
- **Counters:** all saturate at all-ones, with no wrap.
- **Simultaneous events in BUSY:** `frame_rdy` and `pkt_done` in the same cycle resolve as `frame_rdy` (success).

## Timing
- Tick at edge N → `start` = 1 after edge N+1 when in IDLE with no mask commit.
- `start` drops one cycle after the acceptance edge. The compressor therefore sees exactly one accepting cycle.
- BUSY → IDLE → REQ is at least 2 cycles, so there is no back-to-back `start` while the compressor is still returning to its idle state.
- `vector_bits` is stable from REQ entry until return to IDLE.
- `rstb` asserted mid-frame: immediate return to the reset values, and any in-flight frame is abandoned. The compressor shares `rstb`.

## Structure
- Package `compressor_sched_pkg` holds:
  - the state enum: IDLE=2'b00, REQ=2'b01, BUSY=2'b11;
  - `NUM_CHANS` = 64;
  - `CHAN_IDX_W` = 7.
- Sub-module `frame_tick_gen`: the period down-counter with clamp and enable, emitting a 1-cycle `tick`.
- The popcount is a combinational function in the package, registered in the top level.

## Test plan
1. **Basic frame:** `period`=100, `enable`=1, `fifo_full`=0, compressor model returns `frame_rdy` 80 cycles after accept.
   - Required: `start` pulses exactly 1 cycle per 100.
   - Required: `frames_done` = 10 after 1000 cycles; `frames_dropped` = 0.
2. **Backpressure:** hold `fifo_full`=1 for 250 cycles with `period`=100.
   - Required: `start` stays high throughout.
   - Required: `frames_dropped` = 1 (one tick pending, one dropped).
   - Required: after release, acceptance occurs on the next cycle.
3. **CRC failure:** `pkt_done`=1 with `crc_ok`=0 in BUSY.
   - Required: `crc_errors`=1, state IDLE next cycle, `frames_done` unchanged.
   - A `pkt_done` with `crc_ok`=1 keeps the block in BUSY.
4. **Mask deferral:** write `cfg_mask`=64'h0000_0000_FFFF_00F0 during BUSY.
   - Required: `vector_bits` is unchanged until `frame_rdy`.
   - Required: one cycle later `vector_bits` is updated and `active_chans`=20.
   - Also check `cfg_mask`=all ones → `active_chans`=64.
5. **Boundaries:**
   - `period`=0 → ticks every 2 cycles.
   - Force `frames_done` to its maximum → it saturates at 16'hFFFF.
   - `enable` dropped during REQ → `start` = 0 the next cycle.
   - `rstb` low mid-BUSY → every output returns to its reset value asynchronously.
